button_event_scheduler: RTL and testbench
=========================================

Name: button_event_scheduler

Overview:
- Multi-button front end: per-button synchronisation and debounce, then a per-button press FSM that generates PRESS, RELEASE, LONG and REPEAT events.
- Events from all buttons are queued as pending flags. A round-robin scheduler serialises them onto one valid/ready event stream.
- Sits between the board push-buttons and the control/UI logic. It replaces ad-hoc per-button debouncers.

Parameters:
- N_BTN, 4, number of buttons (2..16)
- TICK_DIV, 50000, clk cycles per debounce/timing tick
- DEB_TICKS, 16, consecutive mismatching ticks required to accept a button state change
- LONG_TICKS, 1000, ticks of continuous press before LONG event
- REPEAT_TICKS, 200, ticks between REPEAT events after LONG

Ports:
- clk  in  1  single system clock
- rst  in  1  synchronous, active-high reset
- btn_n  in  N_BTN  raw buttons, asynchronous to clk, active low, glitchy
- btn_state  out  N_BTN  debounced level, 1 = pressed
- ev_valid  out  1  event available
- ev_ready  in  1  consumer accepts event when ev_valid & ev_ready
- ev_btn  out  clog2(N_BTN)  button index of event
- ev_code  out  2  00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
- overflow  out  1  sticky: an event was merged/lost
- ovf_clr  in  1  clears overflow

Behaviour:
- Reset values: btn_state=0, ev_valid=0, ev_btn=0, ev_code=0, overflow=0. Sync flops=0 (released), all counters=0, all pending=0, rr pointer=0, all FSMs IDLE.
- Sync: 2-flop synchroniser per button with inversion (active high internally).
- Tick: counter 0..TICK_DIV-1. tick=1 for one cycle when counter==TICK_DIV-1, then wraps to 0.
- Debounce, per button:
  - deb_cnt clears whenever synced level == btn_state.
  - Otherwise it increments on tick.
  - On the tick where deb_cnt==DEB_TICKS-1, btn_state toggles and deb_cnt clears.
  - Any return to agreement before then clears deb_cnt with no change.
- Press FSM, per button; hold_cnt counts ticks:
  - IDLE: on btn_state 0->1, set PRESS pending; go HELD; hold_cnt=0.
  - HELD: hold_cnt increments on tick. When it reaches LONG_TICKS, set LONG pending; go LONG; hold_cnt=0.
  - LONG: hold_cnt increments on tick. When it reaches REPEAT_TICKS, set REPEAT pending; hold_cnt=0.
  - HELD or LONG: on btn_state 1->0, set RELEASE pending; go IDLE. Release takes priority over a same-cycle LONG/REPEAT, which is discarded.
- Pending flags: 4 bits per button, one per code.
  - Setting an already-set bit that is not being cleared the same cycle sets overflow; the event is merged.
  - Set and clear of the same bit in the same cycle leaves it set, with no overflow.
- Scheduler:
  - Output register loads when !ev_valid or (ev_valid & ev_ready).
  - It selects the first button with any pending bit, searching round-robin from the rr pointer.
  - Within a button, fixed priority: PRESS > LONG > REPEAT > RELEASE.
  - On load: the selected pending bit clears, ev_valid=1, rr pointer = selected+1 (mod N_BTN).
  - If nothing is pending at a load opportunity, ev_valid=0.
  - Throughput is one event per cycle with ev_ready held high.
- Latency: pending is set on the same edge that btn_state changes; ev_valid rises one edge later if the output register is free.
- Handshake: while ev_valid & !ev_ready, ev_btn and ev_code hold stable; ev_valid never drops without acceptance.
- overflow: set by any merge, cleared by ovf_clr. A simultaneous set wins.
- Counter widths: sized by clog2 of the respective parameter. No counter wraps except tick.
- Reset mid-operation: everything returns to reset values and no event is emitted for state held before reset. A button still held after reset produces PRESS after 2 sync cycles + DEB_TICKS ticks.

Test Plan:
(All tests use N_BTN=4, TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=10, REPEAT_TICKS=4, ev_ready=1 unless stated.)
- Glitch rejection:
  - Stimulus: btn_n[1] low for 6 cycles, then high.
  - Required: no ev_valid, btn_state[1] stays 0.
- Clean press:
  - Stimulus: btn_n[1] held low.
  - Required: btn_state[1]=1 within 2+3*4±4 cycles; next cycle one event ev_btn=1, ev_code=00; ev_valid high exactly one cycle.
- Long press and release:
  - Stimulus: keep btn_n[1] low.
  - Required: LONG (10) 40 cycles after PRESS; REPEAT (11) every 16 cycles. On release, after debounce: RELEASE (01), then no further events.
- Simultaneous presses:
  - Stimulus: btn_n[0], [2], [3] low on the same cycle.
  - Required: three consecutive-cycle PRESS events in order 0, 2, 3; rr pointer then 0.
  - Follow-up: repeat with rr pointer at 3; required order 3, 0, 2.
- Backpressure:
  - Stimulus: ev_ready=0 while button 2 does press, release, press.
  - Required: first event held stable, overflow=1. After ev_ready=1: PRESS then RELEASE for button 2 only.
  - Follow-up: ovf_clr pulse clears overflow. ovf_clr coincident with a new merge leaves overflow=1.
- Reset mid-hold:
  - Stimulus: rst pulsed while button 3 is in LONG with pending REPEAT.
  - Required: all outputs 0 the cycle after reset. With the button still held, a fresh PRESS arrives after 2+12 cycles, with no RELEASE before it.

Source files
------------

// File: rtl/button_event_scheduler.sv
// Multi-button front end: per-button sync, debounce and press FSM feeding pending
// event flags, serialised round-robin onto a single valid/ready event stream.

module button_event_lane #(
    parameter int DEB_TICKS    = 16,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n_i,
    input  logic       tick_i,
    input  logic [3:0] clr_i,
    output logic       state_o,
    output logic [3:0] pend_o,
    output logic       merge_o
);
    localparam int DW   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

    // Pending bit index equals the event code.
    localparam int C_PRESS = 0, C_REL = 1, C_LONG = 2, C_REP = 3;

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} st_t;

    logic          s1_q, s2_q;
    logic          state_q, state_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [HW-1:0] hold_q, hold_d, lim_m1;
    st_t           st_q, st_d;
    logic [3:0]    pend_q, pend_d, set;
    logic          rise, fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= 1'b0;
            deb_q   <= '0;
            hold_q  <= '0;
            st_q    <= S_IDLE;
            pend_q  <= '0;
        end else begin
            s1_q    <= ~btn_n_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            deb_q   <= deb_d;
            hold_q  <= hold_d;
            st_q    <= st_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        deb_d   = deb_q;
        state_d = state_q;
        if (s2_q == state_q) begin
            deb_d = '0;
        end else if (tick_i) begin
            if (deb_q == DW'(DEB_TICKS - 1)) begin
                state_d = ~state_q;
                deb_d   = '0;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    // Edges are taken from the next debounced level so pending lands on the same edge.
    assign rise   = state_d & ~state_q;
    assign fall   = ~state_d & state_q;
    assign lim_m1 = (st_q == S_HELD) ? HW'(LONG_TICKS - 1) : HW'(REPEAT_TICKS - 1);

    always_comb begin
        st_d   = st_q;
        hold_d = hold_q;
        set    = '0;
        case (st_q)
            S_IDLE: begin
                if (rise) begin
                    set[C_PRESS] = 1'b1;
                    st_d         = S_HELD;
                    hold_d       = '0;
                end
            end
            S_HELD, S_LONG: begin
                if (fall) begin
                    set[C_REL] = 1'b1;
                    st_d       = S_IDLE;
                    hold_d     = '0;
                end else if (tick_i) begin
                    if (hold_q == lim_m1) begin
                        if (st_q == S_HELD) set[C_LONG] = 1'b1;
                        else                set[C_REP]  = 1'b1;
                        st_d   = S_LONG;
                        hold_d = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                st_d   = S_IDLE;
                hold_d = '0;
            end
        endcase
    end

    assign pend_d  = (pend_q & ~clr_i) | set;
    assign merge_o = |(set & pend_q & ~clr_i);
    assign state_o = state_q;
    assign pend_o  = pend_q;
endmodule

module button_event_scheduler #(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 50000,
    parameter int DEB_TICKS    = 16,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_n,
    output logic [N_BTN-1:0]         btn_state,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [$clog2(N_BTN)-1:0] ev_btn,
    output logic [1:0]               ev_code,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam int BW = $clog2(N_BTN);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0]             tcnt_q, tcnt_d;
    logic                      tick;
    logic [N_BTN-1:0][3:0]     pend, clr;
    logic [N_BTN-1:0]          merge;
    logic                      vld_q, vld_d, ovf_q, ovf_d;
    logic [BW-1:0]             btn_q, btn_d, rr_q, rr_d, idx, sel;
    logic [1:0]                code_q, code_d, sel_code;
    logic                      load, found;

    function automatic logic [1:0] pick(input logic [3:0] p);
        if (p[0]) return 2'd0;
        if (p[2]) return 2'd2;
        if (p[3]) return 2'd3;
        return 2'd1;
    endfunction

    assign tick   = (tcnt_q == TW'(TICK_DIV - 1));
    assign tcnt_d = tick ? '0 : tcnt_q + 1'b1;

    for (genvar g = 0; g < N_BTN; g++) begin : g_lane
        button_event_lane #(
            .DEB_TICKS   (DEB_TICKS),
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .btn_n_i(btn_n[g]),
            .tick_i (tick),
            .clr_i  (clr[g]),
            .state_o(btn_state[g]),
            .pend_o (pend[g]),
            .merge_o(merge[g])
        );
    end

    always_comb begin
        load  = ~vld_q | ev_ready;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        clr   = '0;
        for (int k = 0; k < N_BTN; k++) begin
            idx = BW'((int'(rr_q) + k) % N_BTN);
            if (!found && |pend[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        sel_code = pick(pend[sel]);
        vld_d    = vld_q;
        btn_d    = btn_q;
        code_d   = code_q;
        rr_d     = rr_q;
        if (load) begin
            vld_d = found;
            if (found) begin
                clr[sel][sel_code] = 1'b1;
                btn_d  = sel;
                code_d = sel_code;
                rr_d   = (sel == BW'(N_BTN - 1)) ? '0 : sel + 1'b1;
            end
        end
        // A merge in the same cycle as a clear request keeps the flag set.
        ovf_d = (|merge) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
            vld_q  <= 1'b0;
            btn_q  <= '0;
            code_q <= '0;
            rr_q   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            vld_q  <= vld_d;
            btn_q  <= btn_d;
            code_q <= code_d;
            rr_q   <= rr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ev_valid = vld_q;
    assign ev_btn   = btn_q;
    assign ev_code  = code_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler: a rule-level model checked every cycle,
// plus literal expectations on the accepted-event log.

module tb_button_event_scheduler;
    localparam int NB = 4, TD = 4, DEB = 3, LNG = 10, REP = 4;

    logic          clk = 1'b0;
    logic          rst, ev_ready, ovf_clr;
    logic [NB-1:0] btn_n;
    logic [NB-1:0] btn_state;
    logic          ev_valid, overflow;
    logic [1:0]    ev_btn, ev_code;

    button_event_scheduler #(
        .N_BTN(NB), .TICK_DIV(TD), .DEB_TICKS(DEB), .LONG_TICKS(LNG), .REPEAT_TICKS(REP)
    ) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .btn_state(btn_state),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_btn(ev_btn), .ev_code(ev_code),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int btn; int code; } ev_t;
    ev_t log_q[$];

    int n_tests = 0, n_fail = 0, cyc = 0;
    bit chk_en = 0, saw_ovf = 0;

    // Model state: levels, tick phase, ticks held since press, pending sets, rr pointer.
    int            m_tcnt, m_rr, m_btn, m_code, m_b, m_c;
    bit            m_tk, m_vld, m_ovf, m_found, m_merge, m_old;
    bit [NB-1:0]   m_s1, m_s2, m_state;
    int            m_mis [NB];
    int            m_ht  [NB];
    bit [3:0]      m_pend[NB];
    bit [3:0]      m_clr [NB];
    bit [3:0]      m_ev;
    int            PRIO  [4] = '{0, 2, 3, 1};

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rst) begin
            m_tcnt = 0; m_rr = 0; m_btn = 0; m_code = 0;
            m_vld = 0; m_ovf = 0; m_s1 = '0; m_s2 = '0; m_state = '0;
            for (int b = 0; b < NB; b++) begin
                m_mis[b] = 0; m_ht[b] = 0; m_pend[b] = '0;
            end
        end else begin
            m_tk   = (m_tcnt == TD - 1);
            m_tcnt = m_tk ? 0 : m_tcnt + 1;
            for (int b = 0; b < NB; b++) m_clr[b] = '0;
            if (!m_vld || ev_ready) begin
                m_found = 0;
                for (int k = 0; k < NB; k++) begin
                    m_b = (m_rr + k) % NB;
                    if (!m_found && m_pend[m_b] != 0) begin
                        m_found = 1;
                        m_c = -1;
                        for (int j = 0; j < 4; j++)
                            if (m_c < 0 && m_pend[m_b][PRIO[j]]) m_c = PRIO[j];
                        m_clr[m_b][m_c] = 1;
                        m_btn = m_b; m_code = m_c;
                        m_rr = (m_b + 1) % NB;
                    end
                end
                m_vld = m_found;
            end
            m_merge = 0;
            for (int b = 0; b < NB; b++) begin
                m_old = m_state[b];
                m_ev  = '0;
                if (m_s2[b] == m_state[b]) m_mis[b] = 0;
                else if (m_tk) begin
                    m_mis[b]++;
                    if (m_mis[b] == DEB) begin m_state[b] = ~m_state[b]; m_mis[b] = 0; end
                end
                if (m_state[b] && !m_old) begin
                    m_ev[0] = 1; m_ht[b] = 0;
                end else if (!m_state[b] && m_old) begin
                    m_ev[1] = 1;
                end else if (m_state[b] && m_tk) begin
                    m_ht[b]++;
                    if (m_ht[b] == LNG) m_ev[2] = 1;
                    else if (m_ht[b] > LNG && (m_ht[b] - LNG) % REP == 0) m_ev[3] = 1;
                end
                m_pend[b] = m_pend[b] & ~m_clr[b];
                if ((m_pend[b] & m_ev) != 0) m_merge = 1;
                m_pend[b] = m_pend[b] | m_ev;
            end
            if (m_merge) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            m_s2 = m_s1;
            m_s1 = ~btn_n;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (btn_state !== m_state || ev_valid !== m_vld || overflow !== m_ovf ||
                (m_vld && (int'(ev_btn) !== m_btn || int'(ev_code) !== m_code))) begin
                n_fail++;
                $display("FAIL model cycle %0d: state %b/%b valid %b/%b btn %0d/%0d code %0d/%0d ovf %b/%b (got/expected)",
                         cyc, btn_state, m_state, ev_valid, m_vld, ev_btn, m_btn, ev_code, m_code, overflow, m_ovf);
            end
            if (ev_valid && ev_ready && !rst) log_q.push_back('{cyc, int'(ev_btn), int'(ev_code)});
            if (ovf_clr && overflow) saw_ovf = 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic ev_t ev_at(input int i);
        ev_t e = '{-1, -1, -1};
        if (i < log_q.size()) e = log_q[i];
        return e;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int t0, nsz;
    ev_t e0, e1, e2, e3;

    initial begin
        rst = 1; btn_n = '1; ev_ready = 1; ovf_clr = 0;
        @(posedge clk);
        chk_en = 1;
        #2;
        step(2);
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_state", int'(btn_state), 0);
        chk("rst_btn", int'(ev_btn), 0);
        chk("rst_code", int'(ev_code), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst = 0;
        step(4);

        // Glitch shorter than the debounce window.
        log_q.delete();
        btn_n[1] = 0; step(6); btn_n[1] = 1; step(30);
        chk("glitch_events", log_q.size(), 0);
        chk("glitch_state", int'(btn_state[1]), 0);

        // Clean press, then hold through LONG and REPEAT.
        log_q.delete();
        t0 = cyc; btn_n[1] = 0; step(30);
        e0 = ev_at(0);
        chk("press_count", log_q.size(), 1);
        chk("press_btn", e0.btn, 1);
        chk("press_code", e0.code, 0);
        chk_rng("press_latency", e0.cyc - t0, 12, 15);
        step(60);
        e1 = ev_at(1); e2 = ev_at(2); e3 = ev_at(3);
        chk("hold_count", log_q.size(), 4);
        chk("long_code", e1.code, 2);
        chk("long_delay", e1.cyc - e0.cyc, 40);
        chk("rep1_code", e2.code, 3);
        chk("rep1_delay", e2.cyc - e1.cyc, 16);
        chk("rep2_code", e3.code, 3);
        chk("rep2_delay", e3.cyc - e2.cyc, 16);
        btn_n[1] = 1; step(40);
        e0 = log_q[$];
        chk("release_code", e0.code, 1);
        chk("release_btn", e0.btn, 1);
        nsz = log_q.size(); step(40);
        chk("quiet_after_release", log_q.size(), nsz);

        // Simultaneous presses from a fresh rr pointer, then from rr=3.
        rst = 1; step(2); rst = 0; step(2);
        log_q.delete();
        btn_n = 4'b0010; step(30);
        e0 = ev_at(0); e1 = ev_at(1); e2 = ev_at(2);
        chk("sim_count", log_q.size(), 3);
        chk("sim_order0", e0.btn, 0);
        chk("sim_order1", e1.btn, 2);
        chk("sim_order2", e2.btn, 3);
        chk("sim_codes", e0.code + e1.code + e2.code, 0);
        chk("sim_back2back", e2.cyc - e0.cyc, 2);
        chk("sim_rr", m_rr, 0);
        btn_n = '1; step(30);
        btn_n = 4'b1011; step(28); btn_n = '1; step(30);
        chk("rr_at3", m_rr, 3);
        log_q.delete();
        btn_n = 4'b0010; step(30);
        chk("sim2_order0", ev_at(0).btn, 3);
        chk("sim2_order1", ev_at(1).btn, 0);
        chk("sim2_order2", ev_at(2).btn, 2);
        btn_n = '1; step(30);

        // Backpressure with merges, then overflow clearing.
        log_q.delete();
        ev_ready = 0;
        btn_n = 4'b1011; step(28); btn_n = '1; step(28);
        btn_n = 4'b1011; step(28); btn_n = '1; step(28);
        chk("bp_valid", int'(ev_valid), 1);
        chk("bp_btn", int'(ev_btn), 2);
        chk("bp_code", int'(ev_code), 0);
        chk("bp_ovf", int'(overflow), 1);
        chk("bp_no_accept", log_q.size(), 0);
        ovf_clr = 1; step(1); ovf_clr = 0;
        chk("ovf_cleared", int'(overflow), 0);
        saw_ovf = 0;
        ovf_clr = 1;
        btn_n = 4'b1011; step(28); btn_n = '1; step(28);
        ovf_clr = 0;
        chk("ovf_set_wins", int'(saw_ovf), 1);
        step(1);
        ev_ready = 1; step(10);
        chk("bp_drain_count", log_q.size(), 3);
        chk("bp_drain0", ev_at(0).btn * 4 + ev_at(0).code, 8);
        chk("bp_drain1", ev_at(1).btn * 4 + ev_at(1).code, 8);
        chk("bp_drain2", ev_at(2).btn * 4 + ev_at(2).code, 9);

        // Reset while button 3 sits in LONG with a REPEAT stuck behind backpressure.
        btn_n = 4'b0111; step(60);
        ev_ready = 0; step(40);
        chk("pre_rst_valid", int'(ev_valid), 1);
        rst = 1; step(1);
        chk("mid_rst_valid", int'(ev_valid), 0);
        chk("mid_rst_state", int'(btn_state), 0);
        chk("mid_rst_btn", int'(ev_btn), 0);
        chk("mid_rst_code", int'(ev_code), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        rst = 0; ev_ready = 1; t0 = cyc; log_q.delete();
        step(30);
        e0 = ev_at(0);
        chk("post_rst_btn", e0.btn, 3);
        chk("post_rst_code", e0.code, 0);
        chk_rng("post_rst_latency", e0.cyc - t0, 12, 15);
        btn_n = '1; step(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
